dcache_l1: RTL
==============

DCACHE_L1 -- requirements
Module: dcache_l1

Interface
REQ-001 SHALL have parameter SETS, default 8, giving the number of direct-mapped lines; power of 2, minimum 2; IDX = log2(SETS).
REQ-002 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port mem_req  in  1  CPU request valid; held stable, with all request fields, until resp.
REQ-005 SHALL have port we_on_req  in  1  1 = write, 0 = read.
REQ-006 SHALL have port addr  in  16  byte address: [3:0] offset, [3+IDX:4] index, [15:4+IDX] tag.
REQ-007 SHALL have port byte_en  in  16  per-byte write enable over the 128-bit line; ignored on reads.
REQ-008 SHALL have port wdata  in  128  line-aligned write data; byte i = wdata[8i+7:8i].
REQ-009 SHALL have port resp  out  1  one-cycle completion pulse.
REQ-010 SHALL have port rdata  out  128  full line contents, valid while resp=1.
REQ-011 SHALL have port pmem_read  out  1  line-fill request to the next memory level.
REQ-012 SHALL have port pmem_write  out  1  line-writeback request to the next memory level.
REQ-013 SHALL have port pmem_address  out  16  line address, low 4 bits always 0.
REQ-014 SHALL have port pmem_wdata  out  128  victim line data.
REQ-015 SHALL have port pmem_resp  in  1  one-cycle completion of the current pmem_read or pmem_write.
REQ-016 SHALL have port pmem_rdata  in  128  fill data, valid with pmem_resp.

Function
REQ-017 SHALL store per line: valid, dirty, tag, and 128 data bits; write-back, write-allocate policy.
REQ-018 SHALL implement FSM states IDLE, RESPOND, WRITEBACK, ALLOCATE.
REQ-019 IDLE: mem_req=1 with a valid line and a matching tag is a hit -> RESPOND; miss with dirty victim -> WRITEBACK; miss with clean or invalid victim -> ALLOCATE; mem_req=0 -> stay in IDLE.
REQ-020 Write hit SHALL update only the enabled bytes at the edge leaving IDLE, and SHALL set dirty iff byte_en != 0.
REQ-021 RESPOND SHALL drive resp=1 and rdata=stored line (post-write contents on a write), then go to IDLE unconditionally; mem_req is not sampled in RESPOND.
REQ-022 Hit latency SHALL be exactly 2 cycles from the first cycle mem_req is sampled high to resp; the maximum rate is one request per 2 cycles.
REQ-023 WRITEBACK SHALL drive pmem_write=1, pmem_address={victim tag, index, 4'h0}, and pmem_wdata=victim line until pmem_resp; then it SHALL clear dirty and go to ALLOCATE.
REQ-024 ALLOCATE SHALL drive pmem_read=1 and pmem_address={addr tag, index, 4'h0} until pmem_resp; then it SHALL write pmem_rdata into the line, set valid=1, dirty=0 and tag, and go to IDLE, where the retried lookup hits.
REQ-025 pmem_read and pmem_write SHALL never be high together; both SHALL be 0 in IDLE and RESPOND.
REQ-026 pmem_resp outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-027 If mem_req drops during WRITEBACK or ALLOCATE, the pmem transaction and line fill SHALL complete, no resp SHALL be issued, and the FSM SHALL return to IDLE.
REQ-028 resp SHALL never be asserted in two consecutive cycles.

Reset
REQ-029 rst_n=0 SHALL immediately force state=IDLE; resp, pmem_read and pmem_write SHALL be 0; rdata, pmem_address and pmem_wdata SHALL be 0; all valid and dirty bits SHALL be 0.
REQ-030 Data and tag arrays need no reset.
REQ-031 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transaction with no line update; a pmem_resp arriving after reset SHALL be ignored.

Verification
REQ-032 Cold read: after reset, read 0x0040 -> pmem_read with pmem_address=0x0040; pmem_rdata=pattern P -> resp 2 cycles after fill completes, rdata=P.
REQ-033 Read hit: repeat the read of 0x0040 -> resp exactly 2 cycles after mem_req, no pmem activity, rdata=P.
REQ-034 Write hit: write 0x0040 with byte_en=0x0003, wdata byte0=0xAA, byte1=0xBB -> resp; a following read returns P with bytes 0/1 = 0xAA/0xBB; dirty=1.
REQ-035 Dirty eviction, SETS=8: read 0x00C0 (same index, tag 1) -> pmem_write at 0x0040 with the modified line, then pmem_read at 0x00C0, then resp.
REQ-036 Reset during ALLOCATE: assert rst_n=0 with pmem_read=1 -> pmem_read=0 in the same cycle; a late pmem_resp is ignored; a subsequent read misses.
REQ-037 Zero-enable write: write hit with byte_en=0 -> resp, data unchanged, dirty unchanged.

Source files
------------

// File: rtl/dcache_l1.sv
// rtl/dcache_l1.sv - direct-mapped, write-back/write-allocate L1 data cache
// One 128-bit line per set; misses write back a dirty victim, then fill and retry the lookup.
module dcache_l1 #(
  parameter int SETS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_req,
  input  logic         we_on_req,
  input  logic [15:0]  addr,
  input  logic [15:0]  byte_en,
  input  logic [127:0] wdata,
  output logic         resp,
  output logic [127:0] rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [127:0] pmem_rdata
);

  localparam int IDX  = $clog2(SETS);
  localparam int TAGW = 12 - IDX;

  typedef enum logic [1:0] {IDLE, RESPOND, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [127:0]    data_arr [SETS];
  logic [TAGW-1:0] tag_arr  [SETS];
  logic [SETS-1:0] valid_q;
  logic [SETS-1:0] dirty_q;
  logic [15:4]     req_addr;

  logic [15:4]     cur_addr;
  logic [IDX-1:0]  idx;
  logic [TAGW-1:0] tag;
  logic            hit;
  logic            write_hit;
  logic            fill;
  logic            unused_offset;

  // The request may be withdrawn while pmem is busy, so miss handling uses the latched address.
  assign cur_addr      = (state == WRITEBACK || state == ALLOCATE) ? req_addr : addr[15:4];
  assign idx           = cur_addr[3+IDX:4];
  assign tag           = cur_addr[15:4+IDX];
  assign hit           = valid_q[idx] && (tag_arr[idx] == tag);
  assign write_hit     = (state == IDLE) && mem_req && hit && we_on_req;
  assign fill          = (state == ALLOCATE) && pmem_resp;
  assign unused_offset = ^addr[3:0];

  function automatic logic [127:0] merge_bytes(input logic [127:0] old_line,
                                               input logic [127:0] new_line,
                                               input logic [15:0]  be);
    logic [127:0] res;
    res = old_line;
    for (int i = 0; i < 16; i++) begin
      if (be[i]) res[8*i +: 8] = new_line[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_nxt    = state;
    resp         = 1'b0;
    rdata        = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          if (hit)                               state_nxt = RESPOND;
          else if (valid_q[idx] && dirty_q[idx]) state_nxt = WRITEBACK;
          else                                   state_nxt = ALLOCATE;
        end
      end
      RESPOND: begin
        resp      = 1'b1;
        rdata     = data_arr[idx];
        state_nxt = IDLE;
      end
      WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_arr[idx], idx, 4'h0};
        pmem_wdata   = data_arr[idx];
        if (pmem_resp) state_nxt = ALLOCATE;
      end
      ALLOCATE: begin
        pmem_read    = 1'b1;
        pmem_address = {tag, idx, 4'h0};
        if (pmem_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      valid_q  <= '0;
      dirty_q  <= '0;
      req_addr <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && mem_req && !hit) req_addr <= addr[15:4];
      if (write_hit && (|byte_en)) dirty_q[idx] <= 1'b1;
      if (state == WRITEBACK && pmem_resp) dirty_q[idx] <= 1'b0;
      if (fill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Line storage has no reset; valid_q alone decides whether its contents mean anything.
  always_ff @(posedge clk) begin
    if (write_hit) data_arr[idx] <= merge_bytes(data_arr[idx], wdata, byte_en);
    if (fill) begin
      data_arr[idx] <= pmem_rdata;
      tag_arr[idx]  <= tag;
    end
  end

endmodule
